// File: rtl/inv_pkg.sv
// Shared types and constants for the inventory transaction controller.
package inv_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_AW = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] ST_ADD_OK    = 2'b00;
  localparam logic [1:0] ST_ADD_SAT   = 2'b01;
  localparam logic [1:0] ST_REM_OK    = 2'b10;
  localparam logic [1:0] ST_REM_UNDER = 2'b11;

endpackage

// File: rtl/btn_edge.sv
// Active-low button: 2-flop synchroniser followed by a registered falling-edge pulse.
// The pulse appears 3 clocks after the pin falls.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic pulse_r;

  // Synchroniser, one-cycle history and edge pulse; idle level of the pin is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
      pulse_r <= 1'b0;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      pulse_r <= prev_r & ~sync2_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/inventory_txn_ctrl.sv
// Read-modify-write add/remove transaction sequencer for the inventory memory.
// Optional feature macro: TXN_COUNT_EN (saturating completed-transaction counter).
module inventory_txn_ctrl
  import inv_pkg::*;
#(
  parameter int DW     = DEFAULT_DW,
  parameter int AW     = DEFAULT_AW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic          c_q,
  input  logic [DW-1:0] in,
  input  logic          save_n,
  input  logic          submit_n,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic [1:0]    status,
  output logic [15:0]   txn_count
);

  // WAIT lasts RD_LAT-1 cycles; it is skipped entirely when RD_LAT is 1.
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic          save_p_s;
  logic          submit_p_s;
  logic [DW-1:0] code_r;
  logic [DW-1:0] quant_r;
  logic          txn_mode_r;
  logic [DW-1:0] txn_quant_r;
  state_t        state_r;
  state_t        state_next_s;
  logic [1:0]    wait_cnt_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;
  logic          busy_r;
  logic          done_r;
  logic [1:0]    status_r;
  logic [1:0]    status_pend_r;
  logic [DW+1:0] result_s;

  btn_edge u_save_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (save_n),
    .pulse (save_p_s)
  );

  btn_edge u_submit_edge (
    .clk   (clk),
    .rst   (rst),
    .btn_n (submit_n),
    .pulse (submit_p_s)
  );

  // Returns {status, write_data}; both directions evaluated in DW+1 bits.
  function automatic logic [DW+1:0] calc_result(
    input logic          add,
    input logic [DW-1:0] rd,
    input logic [DW-1:0] q
  );
    logic [DW:0] sum;
    logic [DW:0] diff;
    sum  = {1'b0, rd} + {1'b0, q};
    diff = {1'b0, rd} - {1'b0, q};
    if (add) begin
      if (sum[DW]) calc_result = {ST_ADD_SAT, {DW{1'b1}}};
      else         calc_result = {ST_ADD_OK, sum[DW-1:0]};
    end else begin
      if (diff[DW]) calc_result = {ST_REM_UNDER, {DW{1'b0}}};
      else          calc_result = {ST_REM_OK, diff[DW-1:0]};
    end
  endfunction

  assign result_s = calc_result(txn_mode_r, mem_rdata, txn_quant_r);

  // Next-state decode for the transaction sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (submit_p_s) state_next_s = READ;
        else            state_next_s = IDLE;
      end
      READ: begin
        if (RD_LAT > 1) state_next_s = WAIT;
        else            state_next_s = CALC;
      end
      WAIT: begin
        if (wait_cnt_r == WAIT_LAST) state_next_s = CALC;
        else                         state_next_s = WAIT;
      end
      CALC:    state_next_s = WRITE;
      WRITE:   state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, staging/txn registers and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 2'd0;
      code_r        <= '0;
      quant_r       <= '0;
      txn_mode_r    <= 1'b0;
      txn_quant_r   <= '0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      status_r      <= 2'b00;
      status_pend_r <= 2'b00;
    end else begin
      state_r <= state_next_s;
      if (save_p_s) begin
        if (c_q) code_r  <= in;
        else     quant_r <= in;
      end
      // Copies are taken from the pre-save staging values when both pulses coincide.
      if (state_r == IDLE && submit_p_s) begin
        txn_mode_r  <= mode;
        txn_quant_r <= quant_r;
        mem_addr_r  <= code_r[AW-1:0];
      end
      if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + 2'd1;
      else                 wait_cnt_r <= 2'd0;
      if (state_r == CALC) begin
        mem_wdata_r   <= result_s[DW-1:0];
        status_pend_r <= result_s[DW+1:DW];
      end
      mem_we_r <= (state_next_s == WRITE);
      done_r   <= (state_next_s == DONE);
      busy_r   <= (state_next_s == READ) || (state_next_s == WAIT) ||
                  (state_next_s == CALC) || (state_next_s == WRITE);
      if (state_next_s == DONE) status_r <= status_pend_r;
    end
  end

`ifdef TXN_COUNT_EN
  logic [15:0] txn_count_r;

  // Completed-transaction counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count_r <= 16'h0000;
    end else if (state_next_s == DONE && txn_count_r != 16'hFFFF) begin
      txn_count_r <= txn_count_r + 16'h0001;
    end
  end

  assign txn_count = txn_count_r;
`else
  assign txn_count = 16'h0000;
`endif

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign status    = status_r;

endmodule

// File: tb/tb_inventory_txn_ctrl.sv
// Directed bench: two controllers (RD_LAT 1 and 3) share front-panel stimulus,
// each with its own memory model of matching read latency.
module tb_inventory_txn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       c_q;
  logic [7:0] in;
  logic       save_n;
  logic       submit_n;

  logic       we1, we3, busy1, busy3, done1, done3;
  logic [7:0] addr1, addr3, wdata1, wdata3, rdata1, rdata3;
  logic [1:0] status1, status3;
  logic [15:0] cnt1, cnt3;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] d3a, d3b;
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = 8'h00;
  logic [7:0] pl_data = 8'h00;

  int cyc = 0;
  int we_cnt1 = 0, we_cnt3 = 0, done_cnt1 = 0, done_cnt3 = 0;
  int we_cyc1 = 0, we_cyc3 = 0, done_cyc1 = 0, done_cyc3 = 0;
  logic [7:0] we_addr1 = 8'h00, we_addr3 = 8'h00, we_data1 = 8'h00, we_data3 = 8'h00;

  int n_checks = 0;
  int n_err = 0;
  int n_txn = 0;
  int c0 = 0;
  int s_we1, s_we3, s_done1, s_done3;

  always #5 clk = ~clk;

  inventory_txn_ctrl dut1 (
    .clk(clk), .rst(rst), .mode(mode), .c_q(c_q), .in(in),
    .save_n(save_n), .submit_n(submit_n),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .status(status1), .txn_count(cnt1)
  );

  inventory_txn_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .c_q(c_q), .in(in),
    .save_n(save_n), .submit_n(submit_n),
    .mem_we(we3), .mem_addr(addr3), .mem_wdata(wdata3), .mem_rdata(rdata3),
    .busy(busy3), .done(done3), .status(status3), .txn_count(cnt3)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) begin
      mem1[pl_addr] <= pl_data;
      mem3[pl_addr] <= pl_data;
    end else begin
      if (we1) mem1[addr1] <= wdata1;
      if (we3) mem3[addr3] <= wdata3;
    end
    rdata1 <= mem1[addr1];
    d3a    <= mem3[addr3];
    d3b    <= d3a;
    rdata3 <= d3b;
  end

  always @(negedge clk) begin
    if (we1) begin
      we_cnt1 <= we_cnt1 + 1; we_cyc1 <= cyc; we_addr1 <= addr1; we_data1 <= wdata1;
    end
    if (we3) begin
      we_cnt3 <= we_cnt3 + 1; we_cyc3 <= cyc; we_addr3 <= addr3; we_data3 <= wdata3;
    end
    if (done1) begin
      done_cnt1 <= done_cnt1 + 1; done_cyc1 <= cyc;
    end
    if (done3) begin
      done_cnt3 <= done_cnt3 + 1; done_cyc3 <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
`ifdef TXN_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick(1);
    pl_en = 1'b0;
  endtask

  task automatic save(input logic cq, input logic [7:0] v);
    c_q = cq; in = v; save_n = 1'b0;
    tick(4);
    save_n = 1'b1;
    tick(4);
  endtask

  task automatic snap();
    s_we1 = we_cnt1; s_we3 = we_cnt3; s_done1 = done_cnt1; s_done3 = done_cnt3;
    c0 = cyc;
  endtask

  task automatic submit();
    snap();
    submit_n = 1'b0;
    tick(5);
    check("busy_mid1", busy1, 1);
    check("busy_mid3", busy3, 1);
    submit_n = 1'b1;
    tick(15);
  endtask

  task automatic check_txn(input string tag, input logic [7:0] a, input logic [7:0] wd,
                           input logic [1:0] st);
    check({tag, " we_count1"}, we_cnt1 - s_we1, 1);
    check({tag, " we_count3"}, we_cnt3 - s_we3, 1);
    check({tag, " addr1"}, we_addr1, a);
    check({tag, " addr3"}, we_addr3, a);
    check({tag, " wdata1"}, we_data1, wd);
    check({tag, " wdata3"}, we_data3, wd);
    check({tag, " mem1"}, mem1[a], wd);
    check({tag, " mem3"}, mem3[a], wd);
    check({tag, " status1"}, status1, st);
    check({tag, " status3"}, status3, st);
    check({tag, " we_cycle1"}, we_cyc1, c0 + 6);
    check({tag, " we_cycle3"}, we_cyc3, c0 + 8);
    check({tag, " done_cycle1"}, done_cyc1, c0 + 7);
    check({tag, " done_cycle3"}, done_cyc3, c0 + 9);
    check({tag, " done_count3"}, done_cnt3 - s_done3, 1);
    check({tag, " busy_end1"}, busy1, 0);
    check({tag, " busy_end3"}, busy3, 0);
    check({tag, " txn_count1"}, cnt1, exp_cnt(n_txn));
    check({tag, " txn_count3"}, cnt3, exp_cnt(n_txn));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; c_q = 1'b0; in = 8'h00; save_n = 1'b1; submit_n = 1'b1;
    tick(2);
    check("rst we1", we1, 0);
    check("rst we3", we3, 0);
    check("rst busy1", busy1, 0);
    check("rst done1", done1, 0);
    check("rst status1", status1, 0);
    check("rst txn_count1", cnt1, 0);
    check("rst busy3", busy3, 0);
    rst = 1'b0;
    tick(2);

    // 10 + 20 = 30
    preload(8'h05, 8'd10);
    save(1'b1, 8'h05);
    save(1'b0, 8'd20);
    mode = 1'b1;
    submit(); n_txn++;
    check_txn("add_ok", 8'h05, 8'd30, 2'b00);

    // 250 + 10 saturates
    preload(8'h07, 8'd250);
    save(1'b1, 8'h07);
    save(1'b0, 8'd10);
    submit(); n_txn++;
    check_txn("add_sat", 8'h07, 8'hFF, 2'b01);

    // 250 + 5 = 255 exactly, no saturation
    preload(8'h07, 8'd250);
    save(1'b0, 8'd5);
    submit(); n_txn++;
    check_txn("add_edge", 8'h07, 8'hFF, 2'b00);

    // 3 - 5 clamps to 0
    preload(8'h09, 8'd3);
    save(1'b1, 8'h09);
    save(1'b0, 8'd5);
    mode = 1'b0;
    submit(); n_txn++;
    check_txn("rem_under", 8'h09, 8'd0, 2'b11);

    // 3 - 3 = 0 is a normal remove
    preload(8'h09, 8'd3);
    save(1'b0, 8'd3);
    submit(); n_txn++;
    check_txn("rem_eq", 8'h09, 8'd0, 2'b10);

    // second submit and a qty save both land while busy (WAIT for the RD_LAT=3 unit)
    preload(8'h0A, 8'd40);
    save(1'b1, 8'h0A);
    save(1'b0, 8'd7);
    mode = 1'b1;
    snap();
    submit_n = 1'b0;
    tick(1);
    submit_n = 1'b1;
    tick(1);
    submit_n = 1'b0; c_q = 1'b0; in = 8'd99; save_n = 1'b0;
    tick(5);
    submit_n = 1'b1; save_n = 1'b1;
    tick(15);
    n_txn++;
    check_txn("busy_drop", 8'h0A, 8'd47, 2'b00);

    // the qty saved during busy feeds this one: 47 + 99
    submit(); n_txn++;
    check_txn("after_busy", 8'h0A, 8'd146, 2'b00);

    // reset while the RD_LAT=3 unit sits in WAIT aborts without a write
    preload(8'h0B, 8'd1);
    save(1'b1, 8'h0B);
    save(1'b0, 8'd1);
    snap();
    submit_n = 1'b0;
    tick(5);
    rst = 1'b1; submit_n = 1'b1;
    tick(1);
    check("abort busy1", busy1, 0);
    check("abort busy3", busy3, 0);
    check("abort we3", we3, 0);
    rst = 1'b0;
    n_txn = 0;
    tick(15);
    check("abort we_count1", we_cnt1 - s_we1, 0);
    check("abort we_count3", we_cnt3 - s_we3, 0);
    check("abort done_count3", done_cnt3 - s_done3, 0);
    check("abort mem3", mem3[8'h0B], 8'd1);
    check("abort status3", status3, 0);
    check("abort txn_count3", cnt3, 0);

    // back in IDLE: a fresh transaction completes normally
    save(1'b1, 8'h0B);
    save(1'b0, 8'd2);
    submit(); n_txn++;
    check_txn("recover", 8'h0B, 8'd3, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
